// File: rtl/seq_input_checker.sv
// Player-side checker for the memory game: walks the sequence address, compares each synchronized
// one-hot button press against the decoder's expected pattern and reports ok / done / error.
module seq_input_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] round_len,
  input  logic [3:0] buttons,
  input  logic [3:0] expected,
  output logic [3:0] seq_addr,
  output logic [1:0] btn_code,
  output logic       busy,
  output logic       step_ok,
  output logic       round_done,
  output logic       error,
  output logic       timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWaitPress, StWaitRelease} state_e;

  state_e        state_q;
  logic [3:0]    btn_meta_q, btn_s_q;
  logic [3:0]    round_len_q;
  logic [TW-1:0] timer_q;
  logic          btn_any, btn_onehot;
  logic [1:0]    btn_enc;

  // Two-flop synchronizer; the FSM only ever looks at btn_s_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_q <= 4'd0;
      btn_s_q    <= 4'd0;
    end else begin
      btn_meta_q <= buttons;
      btn_s_q    <= btn_meta_q;
    end
  end

  always_comb begin
    btn_any    = (btn_s_q != 4'd0);
    btn_onehot = btn_any && ((btn_s_q & (btn_s_q - 4'd1)) == 4'd0);
    btn_enc    = 2'd0;
    unique case (1'b1)
      btn_s_q[1]: btn_enc = 2'd1;
      btn_s_q[2]: btn_enc = 2'd2;
      btn_s_q[3]: btn_enc = 2'd3;
      default:    btn_enc = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      round_len_q <= 4'd0;
      timer_q     <= '0;
      seq_addr    <= 4'd0;
      btn_code    <= 2'd0;
      busy        <= 1'b0;
      step_ok     <= 1'b0;
      round_done  <= 1'b0;
      error       <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      step_ok    <= 1'b0;
      round_done <= 1'b0;
      error      <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            round_len_q <= round_len;
            seq_addr    <= 4'd0;
            timer_q     <= '0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            state_q     <= StWaitPress;
          end
        end
        StWaitPress: begin
          // A press seen in the expiry cycle takes priority over the timeout.
          if (btn_any) begin
            if (btn_onehot && (btn_s_q == expected)) begin
              step_ok  <= 1'b1;
              btn_code <= btn_enc;
              state_q  <= StWaitRelease;
            end else begin
              error   <= 1'b1;
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else if (timer_q == TimerLast) begin
            error   <= 1'b1;
            timeout <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        StWaitRelease: begin
          if (!btn_any) begin
            if (seq_addr == round_len_q) begin
              round_done <= 1'b1;
              busy       <= 1'b0;
              state_q    <= StIdle;
            end else begin
              seq_addr <= seq_addr + 4'd1;
              timer_q  <= '0;
              state_q  <= StWaitPress;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_input_checker.sv
// Bench for seq_input_checker: table of press/release steps plus hand-written timeout,
// WAIT_RELEASE, async-reset and start-while-busy sequences.
module tb_seq_input_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] round_len = 4'd0;
  logic [3:0] buttons = 4'd0;
  logic [3:0] expected;
  logic [3:0] seq_addr;
  logic [1:0] btn_code;
  logic       busy, step_ok, round_done, error, timeout;

  int checks = 0;
  int failures = 0;
  int ok_cnt = 0, err_cnt = 0, done_cnt = 0;

  logic [3:0] pattern [16];
  logic [1:0] codes [16];

  typedef struct packed {
    logic       do_start;
    logic [3:0] rlen;
    logic [3:0] btn;
    logic       exp_ok;
    logic       exp_err;
    logic [1:0] exp_code;
    logic       exp_done;
    logic [3:0] exp_addr;
    logic       exp_busy;
    logic       exp_tmo;
  } vec_t;

  vec_t vecs [23];

  seq_input_checker #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .round_len(round_len), .buttons(buttons),
    .expected(expected), .seq_addr(seq_addr), .btn_code(btn_code), .busy(busy),
    .step_ok(step_ok), .round_done(round_done), .error(error), .timeout(timeout)
  );

  // Stand-in for the sequence decoder.
  assign expected = pattern[seq_addr];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (step_ok) ok_cnt++;
    if (error) err_cnt++;
    if (round_done) done_cnt++;
    if (!reset) check("pulse_exclusive", 32'(int'(step_ok) + int'(round_done) + int'(error) <= 1),
                      32'd1);
  end

  task automatic do_start(input logic [3:0] r);
    start = 1'b1;
    round_len = r;
    @(negedge clk);
    start = 1'b0;
    round_len = ~r;
  endtask

  task automatic press_release(input logic [3:0] b);
    buttons = b;
    repeat (5) @(negedge clk);
    buttons = 4'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ok0, er0, dn0;
    if (v.do_start) do_start(v.rlen);
    ok0 = ok_cnt; er0 = err_cnt; dn0 = done_cnt;
    buttons = v.btn;
    repeat (5) @(negedge clk);
    check($sformatf("v%0d_step_ok", idx), 32'(ok_cnt - ok0), 32'(v.exp_ok));
    check($sformatf("v%0d_error", idx), 32'(err_cnt - er0), 32'(v.exp_err));
    if (v.exp_ok) check($sformatf("v%0d_btn_code", idx), 32'(btn_code), 32'(v.exp_code));
    buttons = 4'd0;
    repeat (5) @(negedge clk);
    check($sformatf("v%0d_round_done", idx), 32'(done_cnt - dn0), 32'(v.exp_done));
    check($sformatf("v%0d_seq_addr", idx), 32'(seq_addr), 32'(v.exp_addr));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.exp_busy));
    check($sformatf("v%0d_timeout", idx), 32'(timeout), 32'(v.exp_tmo));
  endtask

  initial begin
    int ok0, er0, dn0, k_hit;
    pattern = '{4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100, 4'b1000, 4'b0001,
                4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100, 4'b0010};
    codes   = '{2'd0, 2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0,
                2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2, 2'd1};
    // start, rlen, btn, ok, err, code, done, addr, busy, timeout
    vecs[0] = '{1'b1, 4'd3, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 4'd0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0, 4'd2, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 4'd0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'd3, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 4'd0, 4'b1000, 1'b1, 1'b0, 2'd3, 1'b1, 4'd3, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'd3, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 4'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 4'd0, 4'b0010, 1'b0, 1'b1, 2'd0, 1'b0, 4'd1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 4'd3, 4'b0101, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++)
      vecs[7+i] = '{(i == 0), 4'd15, pattern[i], 1'b1, 1'b0, codes[i], (i == 15),
                    (i == 15) ? 4'd15 : 4'(i + 1), (i != 15), 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_seq_addr", 32'(seq_addr), 32'd0);
    check("rst_btn_code", 32'(btn_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_pulses", 32'({step_ok, round_done, error}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 23; i++) run_vec(vecs[i], i);

    // Timeout: error 16 cycles after entering WAIT_PRESS, first seen on negedge k=17
    k_hit = 0;
    do_start(4'd0);
    for (int k = 1; k <= 40; k++) begin
      if (error) begin
        k_hit = k;
        break;
      end
      @(negedge clk);
    end
    check("timeout_latency", 32'(k_hit), 32'd17);
    check("timeout_flag", 32'(timeout), 32'd1);
    repeat (3) @(negedge clk);
    check("timeout_sticky", 32'(timeout), 32'd1);
    check("timeout_idle", 32'(busy), 32'd0);
    do_start(4'd3);
    check("timeout_cleared", 32'(timeout), 32'd0);
    check("timeout_restart_busy", 32'(busy), 32'd1);
    repeat (25) @(negedge clk);

    // Extra button during WAIT_RELEASE is ignored; advance only after full release
    do_start(4'd3);
    ok0 = ok_cnt; er0 = err_cnt;
    buttons = 4'b0001;
    repeat (5) @(negedge clk);
    check("hold_step_ok", 32'(ok_cnt - ok0), 32'd1);
    buttons = 4'b0101;
    repeat (5) @(negedge clk);
    check("hold_extra_err", 32'(err_cnt - er0), 32'd0);
    check("hold_extra_ok", 32'(ok_cnt - ok0), 32'd1);
    check("hold_extra_addr", 32'(seq_addr), 32'd0);
    buttons = 4'b0100;
    repeat (5) @(negedge clk);
    check("hold_partial_addr", 32'(seq_addr), 32'd0);
    check("hold_partial_busy", 32'(busy), 32'd1);
    buttons = 4'b0000;
    repeat (5) @(negedge clk);
    check("hold_release_addr", 32'(seq_addr), 32'd1);
    repeat (25) @(negedge clk);

    // Async reset in WAIT_RELEASE at seq_addr=2
    do_start(4'd3);
    press_release(4'b0001);
    press_release(4'b0100);
    buttons = 4'b0001;
    repeat (5) @(negedge clk);
    check("pre_rst_addr", 32'(seq_addr), 32'd2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    ok0 = ok_cnt; er0 = err_cnt; dn0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("async_rst_addr", 32'(seq_addr), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_code", 32'(btn_code), 32'd0);
    buttons = 4'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_pulse", 32'((ok_cnt - ok0) + (err_cnt - er0) + (done_cnt - dn0)), 32'd0);

    // start while busy is ignored (round_len_q stays 3)
    do_start(4'd3);
    buttons = 4'b0001;
    repeat (5) @(negedge clk);
    dn0 = done_cnt;
    do_start(4'd0);
    buttons = 4'd0;
    repeat (5) @(negedge clk);
    check("busy_start_done", 32'(done_cnt - dn0), 32'd0);
    check("busy_start_addr", 32'(seq_addr), 32'd1);
    check("busy_start_busy", 32'(busy), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
